// File: rtl/port_merge_arb.sv
// Frame-atomic round-robin merge of two 9-bit rx FIFO read ports into one tx FIFO write port.
// A grant is held for a whole frame; frames longer than MAX_FRAME are cut and the tail dropped.
module port_merge_arb #(
  parameter int MAX_FRAME = 1522,
  parameter int CNT_W     = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rstn,
  output logic             rd0_en,
  input  logic [8:0]       rd0_data,
  input  logic             rd0_empty,
  output logic             rd1_en,
  input  logic [8:0]       rd1_data,
  input  logic             rd1_empty,
  output logic             wr_en,
  output logic [8:0]       wr_data,
  input  logic             wr_full,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] frm_cnt0,
  output logic [CNT_W-1:0] frm_cnt1,
  output logic [CNT_W-1:0] trunc_cnt
);

  localparam int BCNT_W = $clog2(MAX_FRAME + 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_FRAME);

  typedef enum logic [2:0] {IDLE, SEND0, SEND1, DISC0, DISC1} state_t;

  state_t             r_state;
  logic               r_last;
  logic               r_rd_vld_p1;
  logic               r_started;
  logic [BCNT_W-1:0]  r_bcnt;
  logic               r_wr_en;
  logic [8:0]         r_wr_data;
  logic [1:0]         r_grant;
  logic [CNT_W-1:0]   r_frm_cnt0;
  logic [CNT_W-1:0]   r_frm_cnt1;
  logic [CNT_W-1:0]   r_trunc_cnt;

  logic               w_port1;
  logic               w_send;
  logic               w_disc;
  logic [8:0]         w_rdata;
  logic               w_empty;
  logic               w_term;
  logic               w_trunc;
  logic               w_frm_done;
  logic               w_rd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_port1    = (r_state == SEND1) || (r_state == DISC1);
    w_send     = (r_state == SEND0) || (r_state == SEND1);
    w_disc     = (r_state == DISC0) || (r_state == DISC1);
    w_rdata    = w_port1 ? rd1_data : rd0_data;
    w_empty    = w_port1 ? rd1_empty : rd0_empty;
    // A returning end-of-frame word blocks the next read so nothing is fetched past the frame.
    w_term     = r_rd_vld_p1 & ~w_rdata[8] & (r_started | w_disc);
    w_trunc    = w_send & r_rd_vld_p1 & w_rdata[8] & (r_bcnt == BCNT_MAX);
    w_frm_done = w_trunc | (w_send & w_term);
    w_rd       = (w_send | w_disc) & ~w_empty & ~w_term & (w_disc | ~wr_full);
  end

  assign rd0_en    = w_rd & ~w_port1;
  assign rd1_en    = w_rd & w_port1;
  assign wr_en     = r_wr_en;
  assign wr_data   = r_wr_data;
  assign grant     = r_grant;
  assign frm_cnt0  = r_frm_cnt0;
  assign frm_cnt1  = r_frm_cnt1;
  assign trunc_cnt = r_trunc_cnt;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_rd_vld_p1 <= 1'b0;
      r_started   <= 1'b0;
      r_bcnt      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_grant     <= 2'b00;
      r_frm_cnt0  <= '0;
      r_frm_cnt1  <= '0;
      r_trunc_cnt <= '0;
    end else begin
      r_wr_en     <= 1'b0;
      r_rd_vld_p1 <= w_rd;

      if (w_frm_done) begin
        if (w_port1) r_frm_cnt1 <= sat_inc(r_frm_cnt1);
        else         r_frm_cnt0 <= sat_inc(r_frm_cnt0);
      end
      if (w_trunc) r_trunc_cnt <= sat_inc(r_trunc_cnt);

      case (r_state)
        IDLE: begin
          r_started <= 1'b0;
          r_bcnt    <= '0;
          if (~rd0_empty && (rd1_empty || r_last)) begin
            r_state <= SEND0;
            r_grant <= 2'b01;
          end else if (~rd1_empty) begin
            r_state <= SEND1;
            r_grant <= 2'b10;
          end
        end
        SEND0, SEND1: begin
          if (r_rd_vld_p1) begin
            if (w_rdata[8]) begin
              r_wr_en <= 1'b1;
              if (w_trunc) begin
                r_wr_data <= 9'h000;
                r_state   <= w_port1 ? DISC1 : DISC0;
              end else begin
                r_wr_data <= w_rdata;
                r_bcnt    <= r_bcnt + BCNT_W'(1);
                r_started <= 1'b1;
              end
            end else if (r_started) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= w_rdata;
              r_last    <= w_port1;
              r_grant   <= 2'b00;
              r_state   <= IDLE;
            end
          end
        end
        DISC0, DISC1: begin
          if (w_term) begin
            r_last  <= w_port1;
            r_grant <= 2'b00;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_merge_arb.sv
// Bench for port_merge_arb: two modelled rx FIFOs, an output capture and a frame-level
// round-robin reference model that predicts the merged word stream and counters.
`timescale 1ns/1ps
module tb_port_merge_arb;
  localparam int MAXF = 1522;
  localparam int CW   = 16;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          sys_rstn = 1'b0;
  logic          rd0_en, rd1_en, wr_en;
  logic [8:0]    rd0_data = '0, rd1_data = '0, wr_data;
  logic          rd0_empty = 1'b1, rd1_empty = 1'b1;
  logic          wr_full = 1'b0;
  logic [1:0]    grant;
  logic [CW-1:0] frm_cnt0, frm_cnt1, trunc_cnt;

  logic [8:0] mem0 [0:DEPTH-1];
  logic [8:0] mem1 [0:DEPTH-1];
  logic [8:0] out_mem [0:DEPTH-1];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0, out_n = 0;
  int n_both = 0, n_full_rd = 0, n_under = 0;
  bit flush = 0, full_rand = 0;

  int n_chk = 0, n_fail = 0;

  logic [8:0] exp_q [$];
  int mp0, mp1, exp_f0 = 0, exp_f1 = 0, exp_tr = 0;
  bit m_last = 1'b1;

  port_merge_arb #(.MAX_FRAME(MAXF), .CNT_W(CW)) dut (
    .sys_clk(clk), .sys_rstn(sys_rstn),
    .rd0_en(rd0_en), .rd0_data(rd0_data), .rd0_empty(rd0_empty),
    .rd1_en(rd1_en), .rd1_data(rd1_data), .rd1_empty(rd1_empty),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .grant(grant), .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1), .trunc_cnt(trunc_cnt)
  );

  initial forever #4 clk = ~clk;

  // rx FIFOs: data appears on the edge after the read strobe
  initial forever begin
    @(posedge clk);
    if (flush) begin
      rp0 = wp0;
      rp1 = wp1;
    end else begin
      if (rd0_en) begin
        if (rp0 == wp0) n_under++;
        else begin rd0_data <= mem0[rp0]; rp0++; end
      end
      if (rd1_en) begin
        if (rp1 == wp1) n_under++;
        else begin rd1_data <= mem1[rp1]; rp1++; end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    wr_full = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial forever begin
    @(negedge clk);
    rd0_empty = (rp0 == wp0);
    rd1_empty = (rp1 == wp1);
    if (sys_rstn) begin
      if (wr_en) begin out_mem[out_n] = wr_data; out_n++; end
      if (rd0_en && rd1_en) n_both++;
      if ((rd0_en || rd1_en) && wr_full) n_full_rd++;
    end
  end

  task automatic add_frame(input int port, input int ngap, input int nbytes);
    logic [8:0] w;
    for (int i = 0; i < ngap + nbytes + 1; i++) begin
      if (i < ngap || i == ngap + nbytes) w = {1'b0, 8'($urandom)};
      else                                w = {1'b1, 8'($urandom)};
      if (port == 0) begin mem0[wp0] = w; wp0++; end
      else           begin mem1[wp1] = w; wp1++; end
    end
  endtask

  function automatic bit has_frame(input int p);
    if (p == 0) begin for (int i = mp0; i < wp0; i++) if (mem0[i][8]) return 1'b1; end
    else        begin for (int i = mp1; i < wp1; i++) if (mem1[i][8]) return 1'b1; end
    return 1'b0;
  endfunction

  // One whole frame of port p as it should leave the merger
  task automatic emit(input int p);
    logic [8:0] w;
    int n = 0;
    bit tr = 0;
    while (1) begin
      if (p == 0) begin w = mem0[mp0]; mp0++; end
      else        begin w = mem1[mp1]; mp1++; end
      if (w[8]) begin
        if (n < MAXF) begin exp_q.push_back(w); n++; end
        else if (!tr) begin exp_q.push_back(9'h000); tr = 1; end
      end else if (n > 0) begin
        if (!tr) exp_q.push_back(w);
        break;
      end
    end
    if (p == 0) exp_f0++; else exp_f1++;
    if (tr) exp_tr++;
    m_last = (p == 1);
  endtask

  task automatic run_model();
    bit h0, h1;
    while (1) begin
      h0 = has_frame(0);
      h1 = has_frame(1);
      if (!h0 && !h1) break;
      emit((h0 && (!h1 || m_last)) ? 0 : 1);
    end
  endtask

  task automatic begin_test(output int start);
    start = out_n;
    exp_q.delete();
    mp0 = wp0;
    mp1 = wp1;
  endtask

  task automatic wait_drain(input int start, input int budget, output bit to);
    int c = 0;
    to = 0;
    while (!((out_n - start) >= exp_q.size() && rp0 == wp0 && rp1 == wp1 && grant == 2'b00)) begin
      @(negedge clk);
      c++;
      if (c > budget) begin to = 1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic int first_diff(input int start);
    for (int i = 0; i < exp_q.size() && start + i < out_n; i++)
      if (out_mem[start + i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    sys_rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b, expected 00", grant); end
    n_chk++; if ({wr_en, wr_data} !== 10'h000) begin n_fail++; $display("FAIL reset_wr: got en=%b data=%h, expected 0/000", wr_en, wr_data); end
    n_chk++; if ({rd0_en, rd1_en} !== 2'b00) begin n_fail++; $display("FAIL reset_rd_en: got %b, expected 00", {rd0_en, rd1_en}); end
    n_chk++; if ({frm_cnt0, frm_cnt1, trunc_cnt} !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d, expected 0/0/0", frm_cnt0, frm_cnt1, trunc_cnt); end
    sys_rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int start, d;
    bit to;
    begin_test(start);
    for (int k = 0; k < 3; k++) begin
      add_frame(0, 0, $urandom_range(8, 40));
      add_frame(1, 0, $urandom_range(8, 40));
    end
    run_model();
    wait_drain(start, 2000, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL rr_drain: timed out with %0d of %0d words", out_n - start, exp_q.size()); end
    n_chk++; if (out_n - start !== exp_q.size()) begin n_fail++; $display("FAIL rr_count: got %0d words, expected %0d", out_n - start, exp_q.size()); end
    d = first_diff(start);
    n_chk++; if (d !== -1) begin n_fail++; $display("FAIL rr_stream: word %0d got %h, expected %h", d, out_mem[start + d], exp_q[d]); end
    n_chk++; if (frm_cnt0 !== CW'(exp_f0) || frm_cnt1 !== CW'(exp_f1)) begin n_fail++; $display("FAIL rr_frm_cnt: got %0d/%0d, expected %0d/%0d", frm_cnt0, frm_cnt1, exp_f0, exp_f1); end
    n_chk++; if (n_both !== 0) begin n_fail++; $display("FAIL rr_both_rd_en: got %0d cycles, expected 0", n_both); end
  endtask

  task automatic test_single_port();
    int start, d, c;
    bit to;
    begin_test(start);
    add_frame(0, 0, 64);
    run_model();
    c = 0;
    while (grant !== 2'b01 && c < 20) begin @(negedge clk); c++; end
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b, expected 01", grant); end
    wait_drain(start, 1000, to);
    n_chk++; if (to || out_n - start !== 65) begin n_fail++; $display("FAIL single_count: got %0d words, expected 65", out_n - start); end
    n_chk++; if (out_mem[out_n - 1][8] !== 1'b0) begin n_fail++; $display("FAIL single_term: got bit8=%b, expected 0", out_mem[out_n - 1][8]); end
    d = first_diff(start);
    n_chk++; if (d !== -1) begin n_fail++; $display("FAIL single_stream: word %0d got %h, expected %h", d, out_mem[start + d], exp_q[d]); end
    n_chk++; if (frm_cnt0 !== CW'(exp_f0)) begin n_fail++; $display("FAIL single_frm_cnt0: got %0d, expected %0d", frm_cnt0, exp_f0); end
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_idle_grant: got %b, expected 00", grant); end
  endtask

  task automatic test_truncation();
    int start, d;
    bit to;
    begin_test(start);
    add_frame(1, 0, 1600);
    run_model();
    wait_drain(start, 6000, to);
    n_chk++; if (to || out_n - start !== MAXF + 1) begin n_fail++; $display("FAIL trunc_count: got %0d words, expected %0d", out_n - start, MAXF + 1); end
    n_chk++; if (out_mem[out_n - 1] !== 9'h000) begin n_fail++; $display("FAIL trunc_term: got %h, expected 000", out_mem[out_n - 1]); end
    d = first_diff(start);
    n_chk++; if (d !== -1) begin n_fail++; $display("FAIL trunc_stream: word %0d got %h, expected %h", d, out_mem[start + d], exp_q[d]); end
    n_chk++; if (trunc_cnt !== CW'(exp_tr) || frm_cnt1 !== CW'(exp_f1)) begin n_fail++; $display("FAIL trunc_counters: got trunc=%0d frm1=%0d, expected %0d/%0d", trunc_cnt, frm_cnt1, exp_tr, exp_f1); end
  endtask

  task automatic test_backpressure();
    int start, d, base_full, base_under;
    bit to;
    begin_test(start);
    base_full = n_full_rd;
    base_under = n_under;
    full_rand = 1;
    add_frame(0, 0, 100);
    run_model();
    wait_drain(start, 3000, to);
    full_rand = 0;
    n_chk++; if (to || out_n - start !== exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d words, expected %0d", out_n - start, exp_q.size()); end
    d = first_diff(start);
    n_chk++; if (d !== -1) begin n_fail++; $display("FAIL bp_stream: word %0d got %h, expected %h", d, out_mem[start + d], exp_q[d]); end
    n_chk++; if (n_full_rd - base_full !== 0) begin n_fail++; $display("FAIL bp_rd_while_full: got %0d cycles, expected 0", n_full_rd - base_full); end
    n_chk++; if (n_under - base_under !== 0) begin n_fail++; $display("FAIL bp_underflow: got %0d reads of empty FIFO, expected 0", n_under - base_under); end
  endtask

  task automatic test_leading_gaps();
    int start, d;
    bit to;
    begin_test(start);
    add_frame(0, 5, 30);
    run_model();
    wait_drain(start, 1000, to);
    n_chk++; if (to || out_n - start !== 31) begin n_fail++; $display("FAIL gaps_count: got %0d words, expected 31", out_n - start); end
    d = first_diff(start);
    n_chk++; if (d !== -1) begin n_fail++; $display("FAIL gaps_stream: word %0d got %h, expected %h", d, out_mem[start + d], exp_q[d]); end
  endtask

  task automatic test_back_to_back();
    int start, d;
    bit to;
    for (int r = 0; r < 3; r++) begin
      begin_test(start);
      full_rand = 1;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) add_frame(0, $urandom_range(0, 2), $urandom_range(1, 60));
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) add_frame(1, $urandom_range(0, 2), $urandom_range(1, 60));
      run_model();
      wait_drain(start, 4000, to);
      full_rand = 0;
      n_chk++; if (to || out_n - start !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count round %0d: got %0d words, expected %0d", r, out_n - start, exp_q.size()); end
      d = first_diff(start);
      n_chk++; if (d !== -1) begin n_fail++; $display("FAIL b2b_stream round %0d: word %0d got %h, expected %h", r, d, out_mem[start + d], exp_q[d]); end
      n_chk++; if (frm_cnt0 !== CW'(exp_f0) || frm_cnt1 !== CW'(exp_f1)) begin n_fail++; $display("FAIL b2b_frm_cnt round %0d: got %0d/%0d, expected %0d/%0d", r, frm_cnt0, frm_cnt1, exp_f0, exp_f1); end
    end
  endtask

  task automatic test_async_reset();
    int start, d, c;
    bit to;
    begin_test(start);
    add_frame(0, 0, 200);
    c = 0;
    while (out_n - start < 20 && c < 200) begin @(negedge clk); c++; end
    n_chk++; if (out_n - start < 20) begin n_fail++; $display("FAIL areset_progress: got %0d words, expected at least 20", out_n - start); end
    #1 sys_rstn = 1'b0;
    #1;
    n_chk++; if ({grant, wr_en, wr_data, rd0_en, rd1_en} !== '0 || {frm_cnt0, frm_cnt1, trunc_cnt} !== '0) begin
      n_fail++;
      $display("FAIL areset_outputs: got grant=%b wr_en=%b wr_data=%h rd=%b%b cnt=%0d/%0d/%0d, expected all 0",
               grant, wr_en, wr_data, rd0_en, rd1_en, frm_cnt0, frm_cnt1, trunc_cnt);
    end
    flush = 1;
    @(posedge clk);
    @(negedge clk);
    flush = 0;
    exp_f0 = 0; exp_f1 = 0; exp_tr = 0; m_last = 1'b1;
    @(negedge clk);
    sys_rstn = 1'b1;
    @(negedge clk);
    begin_test(start);
    add_frame(0, 0, 12);
    add_frame(1, 0, 12);
    run_model();
    c = 0;
    while (grant === 2'b00 && c < 20) begin @(negedge clk); c++; end
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL areset_first_grant: got %b, expected 01", grant); end
    wait_drain(start, 1000, to);
    d = first_diff(start);
    n_chk++; if (to || out_n - start !== exp_q.size() || d !== -1) begin n_fail++; $display("FAIL areset_stream: got %0d words (first diff %0d), expected %0d words", out_n - start, d, exp_q.size()); end
    n_chk++; if (frm_cnt0 !== 16'd1 || frm_cnt1 !== 16'd1) begin n_fail++; $display("FAIL areset_frm_cnt: got %0d/%0d, expected 1/1", frm_cnt0, frm_cnt1); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_port();
    test_truncation();
    test_backpressure();
    test_leading_gaps();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
